// File: rtl/pc_3gpp_enc_stage_sched.sv
// Stage/address scheduler for the polar encoder word-RAM datapath: one 8x8 kernel pass,
// then butterfly combine stages, with drain gaps and latency-matched write-back addresses.
module pc_3gpp_enc_stage_sched #(
  parameter int pLOG2N_MAX = 10,
  parameter int pLAT       = 2
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  isclr,
  input  logic                  iclkena,
  input  logic                  ibuf_rdy,
  input  logic                  obuf_rdy,
  input  logic [3:0]            ilog2n,
  output logic                  ord,
  output logic                  okernel,
  output logic [3:0]            ostage,
  output logic [pLOG2N_MAX-4:0] ordaddr_a,
  output logic [pLOG2N_MAX-4:0] ordaddr_b,
  output logic                  owr,
  output logic                  owkernel,
  output logic [pLOG2N_MAX-4:0] owraddr_a,
  output logic [pLOG2N_MAX-4:0] owraddr_b,
  output logic                  obusy,
  output logic                  odone
);

  localparam int AW = pLOG2N_MAX - 3;
  localparam int DW = (pLAT > 1) ? $clog2(pLAT) : 1;

  localparam logic [3:0]    LMin    = 4'd5;
  localparam logic [3:0]    LMax    = 4'(pLOG2N_MAX);
  localparam logic [DW-1:0] DrnLast = DW'(pLAT - 1);
  localparam logic [DW-1:0] OneD    = 1;
  localparam logic [AW:0]   OneW    = 1;
  localparam logic [AW-1:0] OneA    = 1;

  typedef enum logic [2:0] {StIdle, StKernel, StDrain, StComb, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [3:0]      stage_q, stage_d;
  logic [3:0]      log2n_q, log2n_d;
  logic [3:0]      l_clamp;
  logic [AW:0]     w_full;
  logic [AW-1:0]   w_last, h_last;
  logic [AW-1:0]   ra_q, ra_d, rb_q, rb_d;
  logic [3:0]      k_d;
  logic [AW-1:0]   kmask, kbit, ins_a;

  logic [pLAT-1:0]         wv_q, wk_q;
  logic [pLAT-1:0][AW-1:0] wa_q, wb_q;

  // W words per block; w_full is one bit wider so W = 2^AW does not wrap to zero.
  assign w_full = OneW << (log2n_q - 4'd3);
  assign w_last = AW'(w_full - OneW);
  assign h_last = AW'((w_full >> 1) - OneW);

  always_comb begin
    l_clamp = ilog2n;
    if (ilog2n < LMin) begin
      l_clamp = LMin;
    end else if (ilog2n > LMax) begin
      l_clamp = LMax;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    stage_d = stage_q;
    log2n_d = log2n_q;
    case (state_q)
      StIdle: begin
        if (ibuf_rdy && obuf_rdy) begin
          state_d = StKernel;
          cnt_d   = '0;
          stage_d = '0;
          log2n_d = l_clamp;
        end
      end
      StKernel: begin
        if (cnt_q == w_last) begin
          state_d = StDrain;
          cnt_d   = '0;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + OneA;
        end
      end
      StDrain: begin
        if (drn_q == DrnLast) begin
          cnt_d = '0;
          if (stage_q == 4'd0) begin
            state_d = StComb;
            stage_d = 4'd3;
          end else if (stage_q < log2n_q - 4'd1) begin
            state_d = StComb;
            stage_d = stage_q + 4'd1;
          end else begin
            state_d = StDone;
          end
        end else begin
          drn_d = drn_q + OneD;
        end
      end
      StComb: begin
        if (cnt_q == h_last) begin
          state_d = StDrain;
          cnt_d   = '0;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + OneA;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (isclr) begin
      state_d = StIdle;
      cnt_d   = '0;
      drn_d   = '0;
      stage_d = '0;
      log2n_d = '0;
    end
  end

  // Pair index p becomes word A by inserting a 0 at bit k; B sets that bit.
  always_comb begin
    k_d   = stage_d - 4'd3;
    kmask = (OneA << k_d) - OneA;
    kbit  = OneA << k_d;
    ins_a = ((cnt_d >> k_d) << (k_d + 4'd1)) | (cnt_d & kmask);
    ra_d  = ra_q;
    rb_d  = rb_q;
    if (state_d == StKernel) begin
      ra_d = cnt_d;
      rb_d = cnt_d;
    end else if (state_d == StComb) begin
      ra_d = ins_a;
      rb_d = ins_a | kbit;
    end
    if (isclr) begin
      ra_d = '0;
      rb_d = '0;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drn_q   <= '0;
      stage_q <= '0;
      log2n_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else if (iclkena || isclr) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      stage_q <= stage_d;
      log2n_q <= log2n_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      wv_q <= '0;
      wk_q <= '0;
      wa_q <= '0;
      wb_q <= '0;
    end else if (isclr) begin
      wv_q <= '0;
      wk_q <= '0;
      wa_q <= '0;
      wb_q <= '0;
    end else if (iclkena) begin
      wv_q[0] <= ord;
      wk_q[0] <= okernel;
      wa_q[0] <= ra_q;
      wb_q[0] <= rb_q;
      for (int i = 1; i < pLAT; i++) begin
        wv_q[i] <= wv_q[i-1];
        wk_q[i] <= wk_q[i-1];
        wa_q[i] <= wa_q[i-1];
        wb_q[i] <= wb_q[i-1];
      end
    end
  end

  assign ord       = (state_q == StKernel) || (state_q == StComb);
  assign okernel   = (state_q == StKernel);
  assign ostage    = stage_q;
  assign ordaddr_a = ra_q;
  assign ordaddr_b = rb_q;
  assign obusy     = (state_q != StIdle);
  assign odone     = (state_q == StDone);
  assign owr       = wv_q[pLAT-1];
  assign owkernel  = wk_q[pLAT-1];
  assign owraddr_a = wa_q[pLAT-1];
  assign owraddr_b = wb_q[pLAT-1];

endmodule

// File: tb/tb_pc_3gpp_enc_stage_sched.sv
// Bench for pc_3gpp_enc_stage_sched: table of block runs checked by an issue/write-back
// scoreboard, plus hand sequences for reset, rdy hold-off and mid-block clear.
module tb_pc_3gpp_enc_stage_sched;

  localparam int LMAX = 10;
  localparam int LAT  = 2;
  localparam int AW   = LMAX - 3;

  logic          iclk = 1'b0;
  logic          ireset, isclr, iclkena, ibuf_rdy, obuf_rdy;
  logic [3:0]    ilog2n;
  logic          ord, okernel, owr, owkernel, obusy, odone;
  logic [3:0]    ostage;
  logic [AW-1:0] ordaddr_a, ordaddr_b, owraddr_a, owraddr_b;

  pc_3gpp_enc_stage_sched #(.pLOG2N_MAX(LMAX), .pLAT(LAT)) dut (
    .iclk(iclk), .ireset(ireset), .isclr(isclr), .iclkena(iclkena),
    .ibuf_rdy(ibuf_rdy), .obuf_rdy(obuf_rdy), .ilog2n(ilog2n),
    .ord(ord), .okernel(okernel), .ostage(ostage),
    .ordaddr_a(ordaddr_a), .ordaddr_b(ordaddr_b),
    .owr(owr), .owkernel(owkernel), .owraddr_a(owraddr_a), .owraddr_b(owraddr_b),
    .obusy(obusy), .odone(odone)
  );

  always #5 iclk = ~iclk;

  typedef struct { bit kern; int stg; int a; int b; int t; } iss_t;
  typedef struct { logic [3:0] n; bit tog; int hold; int l; int cyc; } vec_t;

  iss_t exp_rd[$];
  iss_t exp_wr[$];
  iss_t e_rd, e_wr;
  vec_t vecs[7];

  int n_chk = 0;
  int n_fail = 0;
  int ecyc = 0;
  int exp_done_t = -1;
  int done_ecyc = 0;
  bit done_seen = 0;
  bit toggle = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Enabled-cycle counter: the time base in which the schedule is expected.
  always @(posedge iclk) if (iclkena) ecyc <= ecyc + 1;

  initial begin
    iclkena = 1'b1;
    forever begin
      @(posedge iclk);
      #1;
      iclkena = toggle ? ~iclkena : 1'b1;
    end
  end

  // Count an output only in the last real cycle it is presented (next edge is enabled).
  always @(negedge iclk) begin
    if (iclkena && !ireset) begin
      if (ord) begin
        if (exp_rd.size() == 0) begin
          check("rd_extra", 1'b0, $sformatf("got ord a=%0d s=%0d at t=%0d, required no issue",
                ordaddr_a, ostage, ecyc));
        end else begin
          e_rd = exp_rd.pop_front();
          check("rd", (e_rd.kern == okernel) && (e_rd.stg == int'(ostage)) &&
                (e_rd.a == int'(ordaddr_a)) && (e_rd.kern || e_rd.b == int'(ordaddr_b)) &&
                (e_rd.t == ecyc),
                $sformatf("got k=%0d s=%0d a=%0d b=%0d t=%0d, required k=%0d s=%0d a=%0d b=%0d t=%0d",
                okernel, ostage, ordaddr_a, ordaddr_b, ecyc,
                e_rd.kern, e_rd.stg, e_rd.a, e_rd.b, e_rd.t));
        end
      end
      if (owr) begin
        if (exp_wr.size() == 0) begin
          check("wr_extra", 1'b0, $sformatf("got owr a=%0d at t=%0d, required no write",
                owraddr_a, ecyc));
        end else begin
          e_wr = exp_wr.pop_front();
          check("wr", (e_wr.kern == owkernel) && (e_wr.a == int'(owraddr_a)) &&
                (e_wr.kern || e_wr.b == int'(owraddr_b)) && (e_wr.t == ecyc),
                $sformatf("got k=%0d a=%0d b=%0d t=%0d, required k=%0d a=%0d b=%0d t=%0d",
                owkernel, owraddr_a, owraddr_b, ecyc, e_wr.kern, e_wr.a, e_wr.b, e_wr.t));
        end
      end
      if (odone) begin
        check("done_time", (exp_done_t >= 0) && (ecyc == exp_done_t),
              $sformatf("got odone at t=%0d, required t=%0d", ecyc, exp_done_t));
        exp_done_t = -1;
        done_ecyc = ecyc;
        done_seen = 1'b1;
      end
    end
  end

  // Expected issue schedule of one block, relative to the first KERNEL cycle t0.
  task automatic push_block(input int l, input int t0);
    int   w;
    int   off;
    int   k;
    iss_t x;
    w = 1 << (l - 3);
    for (int i = 0; i < w; i++) begin
      x = '{kern: 1'b1, stg: 0, a: i, b: i, t: t0 + i};
      exp_rd.push_back(x);
      x.t = x.t + LAT;
      exp_wr.push_back(x);
    end
    off = w + LAT;
    for (int s = 3; s < l; s++) begin
      k = s - 3;
      for (int p = 0; p < w / 2; p++) begin
        x.kern = 1'b0;
        x.stg  = s;
        x.a    = ((p >> k) << (k + 1)) + (p % (1 << k));
        x.b    = x.a + (1 << k);
        x.t    = t0 + off + p;
        exp_rd.push_back(x);
        x.t = x.t + LAT;
        exp_wr.push_back(x);
      end
      off = off + w / 2 + LAT;
    end
    exp_done_t = t0 + off;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge iclk);
      #2;
      if (!obusy) break;
    end
    check("idle_wait", !obusy, $sformatf("got obusy=%0d, required 0", obusy));
  endtask

  // Request a block and return t0 once the enabled edge leaving IDLE has passed.
  task automatic start_block(input logic [3:0] n, input int hold, output int t0);
    bit en;
    bit ok;
    ilog2n   = n;
    ibuf_rdy = 1'b1;
    obuf_rdy = (hold == 0);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge iclk);
        if (ord || obusy) ok = 1'b0;
      end
      check("hold_idle", ok, $sformatf("got ord/obusy activity=%0d, required 0", !ok));
      @(posedge iclk);
      #2;
      obuf_rdy = 1'b1;
    end
    en = 1'b0;
    while (!en) begin
      @(posedge iclk);
      en = iclkena;
    end
    #2;
    ibuf_rdy = 1'b0;
    obuf_rdy = 1'b0;
    t0 = ecyc;
  endtask

  task automatic run_block(input vec_t v);
    int t0;
    bit busy_ok;
    wait_idle();
    toggle    = v.tog;
    done_seen = 1'b0;
    start_block(v.n, v.hold, t0);
    push_block(v.l, t0);
    busy_ok = 1'b1;
    for (int i = 0; i < 5000 && !done_seen; i++) begin
      @(negedge iclk);
      #1;
      if (!done_seen && !obusy) busy_ok = 1'b0;
    end
    check("done_reached", done_seen, $sformatf("got done=%0d, required 1 (n=%0d)", done_seen, v.n));
    check("cycle_count", (done_ecyc - t0) == v.cyc,
          $sformatf("got %0d cycles, required %0d (n=%0d)", done_ecyc - t0, v.cyc, v.n));
    check("busy_in_block", busy_ok, $sformatf("got obusy drop=%0d, required 0", !busy_ok));
    check("queues_drained", (exp_rd.size() == 0) && (exp_wr.size() == 0),
          $sformatf("got %0d reads and %0d writes left, required 0 and 0",
          exp_rd.size(), exp_wr.size()));
    toggle = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bit ok;
    vecs[0] = '{n: 4'd5,  tog: 1'b0, hold: 0,  l: 5,  cyc: 14};
    vecs[1] = '{n: 4'd10, tog: 1'b0, hold: 0,  l: 10, cyc: 592};
    vecs[2] = '{n: 4'd5,  tog: 1'b0, hold: 20, l: 5,  cyc: 14};
    vecs[3] = '{n: 4'd6,  tog: 1'b0, hold: 0,  l: 6,  cyc: 28};
    vecs[4] = '{n: 4'd6,  tog: 1'b1, hold: 0,  l: 6,  cyc: 28};
    vecs[5] = '{n: 4'd3,  tog: 1'b0, hold: 0,  l: 5,  cyc: 14};
    vecs[6] = '{n: 4'd15, tog: 1'b0, hold: 0,  l: 10, cyc: 592};

    ireset = 1'b1; isclr = 1'b0; ibuf_rdy = 1'b0; obuf_rdy = 1'b0; ilog2n = 4'd5;
    repeat (3) @(posedge iclk);
    #2;
    ireset = 1'b0;
    @(negedge iclk);
    check("reset_state", {ord, okernel, ostage, ordaddr_a, ordaddr_b, owr, owkernel,
          owraddr_a, owraddr_b, obusy, odone} == '0,
          $sformatf("got ord=%0d obusy=%0d odone=%0d owr=%0d s=%0d, required all 0",
          ord, obusy, odone, owr, ostage));

    for (int i = 0; i < 7; i++) run_block(vecs[i]);

    // Abandon a block with isclr in the middle of stage 4 of a 2^7 block.
    wait_idle();
    done_seen = 1'b0;
    start_block(4'd7, 0, t0);
    push_block(7, t0);
    for (int i = 0; i < 100 && ecyc < t0 + 30; i++) begin
      @(posedge iclk);
      #2;
    end
    check("in_stage4", ord && (ostage == 4'd4),
          $sformatf("got ord=%0d s=%0d, required ord=1 s=4", ord, ostage));
    isclr = 1'b1;
    @(posedge iclk);
    #2;
    isclr = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    exp_done_t = -1;
    check("clear_outputs", {ord, okernel, ostage, ordaddr_a, ordaddr_b, owr, owkernel,
          owraddr_a, owraddr_b, obusy, odone} == '0,
          $sformatf("got ord=%0d obusy=%0d owr=%0d s=%0d, required all 0",
          ord, obusy, owr, ostage));
    ok = 1'b1;
    repeat (10) begin
      @(negedge iclk);
      if (obusy || owr) ok = 1'b0;
    end
    check("quiet_after_clear", ok && !done_seen,
          $sformatf("got activity=%0d done=%0d, required 0 and 0", !ok, done_seen));

    // A normal block must still run correctly after the clear.
    run_block(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
